// File: rtl/score_display_mux.sv
// rtl/score_display_mux.sv - saturating BCD score keeper with multiplexed seven-segment scan
// Score updates and the digit scan are independent; the output stage samples both each cycle.
module score_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  clk_in,
  input  logic                  RESET,
  input  logic                  hit_inc,
  input  logic                  miss_dec,
  input  logic                  clear,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            segs,
  output logic                  score_max
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCORE_W = 4 * NUM_DIGITS;

  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SCORE_W-1:0]    inc_val, dec_val;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            segs_q, segs_d;
  logic                  score_max_q;
  logic                  all_nine, all_zero;
  logic                  carry, borrow;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  higher_zero;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  function automatic logic is_all_nine(input logic [SCORE_W-1:0] v);
    is_all_nine = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) is_all_nine = 1'b0;
    end
  endfunction

  // Ripple carry/borrow through the BCD digits; saturation is decided by all_nine/all_zero.
  always_comb begin
    all_nine = is_all_nine(score_q);
    all_zero = (score_q == '0);
    inc_val  = score_q;
    dec_val  = score_q;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (score_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = score_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end

    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (hit_inc && miss_dec) begin
      score_d = score_q;
    end else if (hit_inc) begin
      if (!all_nine) score_d = inc_val;
    end else if (miss_dec) begin
      if (!all_zero) score_d = dec_val;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // upper_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    upper_zero  = '0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero   = higher_zero && (score_q[4*i +: 4] == 4'd0);
      upper_zero[i] = higher_zero;
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = score_q[4*i +: 4];
        cur_blank = blank_lz && (i != 0) && upper_zero[i];
      end
    end
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    segs_d  = cur_blank ? 7'h7F : ~seg_enc(cur_digit);
  end

  always_ff @(posedge clk_in) begin
    if (!RESET) begin
      score_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      anode_q     <= '1;
      segs_q      <= 7'h7F;
      score_max_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      anode_q     <= anode_d;
      segs_q      <= segs_d;
      score_max_q <= is_all_nine(score_d);
    end
  end

  assign anode     = anode_q;
  assign segs      = segs_q;
  assign score_max = score_max_q;

endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
Parametrised score keeper and multiplexed seven-segment driver for the rhythm game top level. It holds an N-digit BCD score that is incremented on hits and decremented on misses, with saturation at both ends. It time-multiplexes the digits onto a shared segment bus with one-hot active-low anodes and optional leading-zero blanking. It replaces the fixed 4-digit anode/segs logic in the game top.

Parameters:
NUM_DIGITS, 4, number of BCD digits and anode lines (1..8)
REFRESH_DIV, 100000, clk_in cycles each digit is driven before the scan advances (>=2)
CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV

Ports:
clk_in  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous reset, active-low (0 = reset)
hit_inc  in  1  single-cycle pulse; add 1 to score
miss_dec  in  1  single-cycle pulse; subtract 1 from score
clear  in  1  synchronous score clear to 0; does not disturb scanning
blank_lz  in  1  1 = blank leading zeros
anode  out  NUM_DIGITS  active-low one-hot digit enable, registered
segs  out  7  active-low segments, registered; segs[0]=a .. segs[6]=g
score_max  out  1  registered; 1 while score equals all nines

Behaviour:
- Reset (RESET=0 at a clock edge): score digits all 0; refresh counter 0; scan index 0; anode all ones; segs 7'h7F; score_max 0. Reset wins over every other input.
- Score update priority, evaluated each cycle: clear, then hit_inc and miss_dec together (no change), then hit_inc alone, then miss_dec alone.
- Increment: BCD ripple carry. Each digit wraps 9->0 and carries into the next digit.
  - If the score is all nines, it holds (saturates). score_max stays 1.
- Decrement: BCD ripple borrow. Each digit wraps 0->9 and borrows from the next digit.
  - If the score is 0, it holds (saturates).
- Score registers update on the edge where the pulse is sampled. A pulse held high for k cycles counts k times.
- score_max is registered from the next-score value, so it asserts on the same edge the score becomes all nines.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, scan index advances idx+1. It wraps from NUM_DIGITS-1 to 0.
  - Each digit is therefore driven for exactly REFRESH_DIV cycles.
- Output stage, registered, 1-cycle latency from index/score:
  - anode = ~(1 << idx).
  - segs = active-low pattern of digit[idx].
- Encoding, active-high {g,f,e,d,c,b,a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. The output segs is the bitwise inverse of this value.
- Leading-zero blanking (blank_lz=1): digit i shows segs=7'h7F (all off) when digit i and every higher digit are 0 and i>0. Digit 0 is never blanked; a score of 0 shows a single "0". blank_lz=0 shows every digit.
- A score change mid-scan shows on the currently enabled digit on the next cycle. There is no snapshot.
- No glitch requirement beyond registered outputs. anode and segs change on the same edge.
- First cycle after reset release: anode = ~1 (digit 0 enabled) and segs = pattern for 0.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4: release reset, leave score at 0, blank_lz=0 -> anode steps 1110,1101,1011,0111 every 4 cycles then repeats; segs = 7'h40 on every digit.
- Pulse hit_inc 10 times -> score 0010; digit1 segs 7'h79, digit0 segs 7'h40; with blank_lz=1, digits 3 and 2 show 7'h7F.
- Load 9999 with 9999 hit pulses; then 2 more hit pulses -> score stays 9999 and score_max=1; one miss_dec -> 9998 and score_max=0 on the same edge.
- From 0100 pulse miss_dec -> 0099 (borrow chain); at 0000 pulse miss_dec -> stays 0000.
- Assert hit_inc and miss_dec together -> no change; assert clear together with hit_inc -> 0000; scan index unaffected by clear.
- Drive RESET=0 mid-scan with idx=2 and score 0537 -> next edge: anode=1111, segs=7'h7F, score 0000; after release, the scan restarts at digit 0.
